// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings, default width,
// and the sizing helper for the bit counter.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to count 0..w-1; never less than one bit.
    function automatic int count_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full adder built from two half-adder stages whose carries
// are OR-ed together.
module serial_fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic h1_s;
    logic h1_c;
    logic h2_c;

    assign h1_s = x ^ y;
    assign h1_c = x & y;
    assign s    = h1_s ^ ci;
    assign h2_c = h1_s & ci;
    assign co   = h1_c | h2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell reused per bit.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    count;
    logic             fa_s;
    logic             fa_c;

    serial_fa_cell u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    // Handshake flags depend on state alone, so no input reaches an output combinationally.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_SHIFT) || (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        count <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // sum doubles as the result shift register; it fills MSB-first from the top.
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    carry <= fa_c;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        cout  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= carry ^ fa_c;
`endif
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases with literal results
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         ovf;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted operation is pending for W edges, then the
    // exact (W+1)-bit sum is presented until the consumer takes it.
    int           m_phase = 0;   // 0 idle, 1 computing, 2 presenting
    int           m_cyc = 0;
    int           m_acc = 0;
    logic [W:0]   m_pend;
    logic         m_pend_ovf;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;
    bit           m_live = 0;

    always @(posedge clk) begin
        m_cyc++;
        m_live = 1;
        if (!rst_n) begin
            m_phase = 0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_phase    = 1;
                m_acc      = m_cyc;
                m_pend     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                m_pend_ovf = (a[W-1] == b[W-1]) && (m_pend[W-1] != a[W-1]);
            end
        end else if (m_phase == 1) begin
            if (m_cyc - m_acc == W) begin
                m_phase = 2;
                m_sum   = m_pend[W-1:0];
                m_cout  = m_pend[W];
                m_ovf   = m_pend_ovf;
            end
        end else if (out_ready) begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready", in_ready, m_phase == 0);
            chk("out_valid", out_valid, m_phase == 2);
            chk("busy", busy, m_phase != 0);
            if (m_phase != 1) begin
                chk("sum", sum, m_sum);
                chk("cout", cout, m_cout);
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", ovf, m_ovf);
`endif
            end
        end
    end

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: in_ready timeout got 0 expected 1", nm);
        end
    endtask

    // Presents one operand set and returns after the acceptance edge (+1).
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                            input string nm);
        wait_ready(nm);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input string nm);
        int lat;
        out_ready = 1'b1;
        start_op(ta, tb_, tc, nm);
        wait_done(lat);
        chk({nm, "_latency"}, lat, W);
        chk({nm, "_sum"}, sum, es);
        chk({nm, "_cout"}, cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
        chk({nm, "_ovf"}, ovf, eo);
`endif
        @(posedge clk); #1;
        chk({nm, "_ready_after"}, in_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int accs[$];
        bit prev_rdy;
        int cyc;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_sum", sum, 8'h00);
        chk("reset_busy", busy, 1'b0);

        run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "op35_4a");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "opff_01");
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "op7f_01");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "opff_ff_c");

        // Backpressure: result must hold and new operands must be ignored.
        out_ready = 1'b0;
        start_op(8'h12, 8'h34, 1'b0, "bp");
        wait_done(lat);
        chk("bp_latency", lat, W);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = 8'hA5; b = 8'h5A;
            @(posedge clk); #1;
            chk("bp_sum_hold", sum, 8'h46);
            chk("bp_cout_hold", cout, 1'b0);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", in_ready, 1'b1);
        chk("bp_release_valid", out_valid, 1'b0);

        // Abort after three shift edges.
        start_op(8'h55, 8'h22, 1'b0, "abort");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_sum", sum, 8'h00);
        chk("abort_cout", cout, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        run_op(8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, "after_abort");

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (W + 4) @(posedge clk);
        #1;

        // Back-to-back with in_valid held high.
        a = 8'h0F; b = 8'h0F; cin = 1'b0;
        in_valid = 1'b1;
        cyc = 0;
        for (int i = 0; i < 3 * (W + 2) + 2; i++) begin
            prev_rdy = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (prev_rdy) accs.push_back(cyc);
        end
        in_valid = 1'b0;
        if (accs.size() >= 3) begin
            chk("b2b_spacing1", accs[1] - accs[0], W + 2);
            chk("b2b_spacing2", accs[2] - accs[1], W + 2);
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL b2b_count: got %0d acceptances expected at least 3", accs.size());
        end
        repeat (W + 4) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder with cin; one bit per clock, LSB first, through a single full-adder cell built from two half-adder cells.
- Sits downstream of the operand source. Consumes a/b/cin over a valid/ready handshake and produces sum/cout over a valid/ready handshake.
- Trades latency for area: one adder cell instead of WIDTH cells.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout valid; high only in DONE.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  registered sum.
- cout  output  1  registered carry-out.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE, sum=0, cout=0, out_valid=0, busy=0, shift regs=0, count=0, carry=0. in_ready=1 after the reset edge. in_valid is ignored on any edge where rst_n is low.
- Reset mid-operation aborts: the in-flight operation is discarded and no result is produced.
- FSM states: IDLE, SHIFT, DONE. in_ready, out_valid and busy are decoded from state only (no input-to-output combinational path).
- IDLE:
  - On an edge with in_valid=1: load a_sh<=a, b_sh<=b, carry<=cin, count<=0, go to SHIFT.
  - sum/cout keep their last values.
- SHIFT, each edge:
  - s,c = FA(a_sh[0], b_sh[0], carry).
  - sum <= {s, sum[WIDTH-1:1]}.
  - a_sh and b_sh shift right by one.
  - carry <= c; count <= count+1.
  - On the edge where count==WIDTH-1: also cout<=c, go to DONE.
- DONE:
  - out_valid=1; sum/cout held stable.
  - On an edge with out_ready=1, go to IDLE.
  - out_ready low holds DONE indefinitely.
- Latency: acceptance edge T; out_valid is high after edge T+WIDTH.
- Throughput: one operation per WIDTH+2 cycles maximum.
- No overlap: in_ready=0 in SHIFT and DONE, so in_valid is ignored there.
- sum register is used as a shift register during SHIFT. Its contents are only meaningful while out_valid=1.
- count width = clog2(WIDTH); wrap-around never occurs because count resets on load.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, exact WIDTH+1 bits.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit) = carry into MSB XOR carry out of MSB, i.e. signed two's-complement overflow.
  - Captured on the final SHIFT edge together with cout.
  - Reset value 0; valid while out_valid=1.
- Undefined: ovf port and its capture logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_add_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2 (2'd3 is illegal and decodes to IDLE on the next edge);
  - the default WIDTH constant;
  - the count-width constant function.
- One sub-module, serial_fa_cell: combinational full adder built from two half-adder cells plus an OR on the carries. Instantiated once.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, cin=0, out_ready=1 -> sum=0x7F, cout=0; out_valid rises exactly 8 edges after acceptance; in_ready=1 again one cycle later.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; with SERIAL_ADDER_OVF_EN, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> sum/cout stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
- rst_n low for one edge after 3 SHIFT cycles -> next cycle out_valid=0, sum=0, cout=0, busy=0, in_ready=1. Follow-up a=0x10, b=0x20, cin=1 -> sum=0x31, cout=0.
- Back-to-back operations with in_valid held high and out_ready=1 -> second operation accepted exactly WIDTH+2 cycles after the first.
